latch_bank_writer: RTL and testbench

- Write controller and arbiter for a bank of NLAT level-sensitive D-latch words, each WIDTH bits wide.
- Shares the bank's single write path between NREQ requesters using round-robin arbitration and a REQ/ACK handshake.
- Sequences each write as setup, then enable pulse, then hold, so D is stable across both edges of the latch enable.
- Also drives the bank's active-low latch reset.

---
 rtl/latch_bank_writer_pkg.sv | 21 ++
 rtl/latch_bank_writer_rr_arbiter.sv | 38 +++
 rtl/latch_bank_writer.sv | 174 +++++++++++++++++
 tb/tb_latch_bank_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_writer_pkg.sv
// Shared types and defaults for the latch bank write controller.
//   state_e  : write sequencer states (IDLE -> SETUP -> ENABLE -> HOLD)
//   en_cnt_t : down-counter type for the latch-enable pulse width (1..15)
//   DEF_*    : default bank geometry used by latch_bank_writer
package latch_bank_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_NLAT  = 6;
    localparam int EN_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    typedef logic [EN_CNT_W-1:0] en_cnt_t;

endpackage

// File: rtl/latch_bank_writer_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index of the last winner; search starts at ptr_i+1 and wraps
//   gnt_o   : one-hot winner (all-zero when nothing requests)
//   idx_o   : winner index
//   valid_o : at least one request present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    logic [IW-1:0] cand_s;

    // Walk the requesters upward from ptr+1; the first active one wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand_s  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand_s = IW'((int'(ptr_i) + off) % NREQ);
            if (!valid_o && req_i[cand_s]) begin
                valid_o       = 1'b1;
                gnt_o[cand_s] = 1'b1;
                idx_o         = cand_s;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/latch_bank_writer.sv
// Write controller / arbiter for a bank of NLAT level-sensitive latch words.
// Each write runs SETUP (data on LD), ENABLE (one latch enable high for
// EN_CYCLES), HOLD (enable low, data still held, ACK), so D is stable across
// both enable edges. All outputs are registered.
//   CLK, RESET : clock, synchronous active-high reset
//   REQ/WADDR/WDATA : per-requester request level, word address, data
//   GNT  : one-hot grant, SETUP through HOLD
//   ACK  : one-cycle done pulse in HOLD;  ERR : same cycle, address >= NLAT
//   LD   : latch data bus;  LEN : one-hot latch enables (ENABLE only)
//   LR   : active-low latch reset;  BUSY : not IDLE
module latch_bank_writer
    import latch_bank_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NLAT      = DEF_NLAT,
    parameter int AW        = $clog2(NLAT),
    parameter int EN_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*AW-1:0]    WADDR,
    input  logic [NREQ*WIDTH-1:0] WDATA,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       ACK,
    output logic                  ERR,
    output logic [WIDTH-1:0]      LD,
    output logic [NLAT-1:0]       LEN,
    output logic                  LR,
    output logic                  BUSY
);

    localparam int              IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam en_cnt_t         EN_LAST = en_cnt_t'(EN_CYCLES - 1);
    localparam logic [NLAT-1:0] LEN_ONE = NLAT'(1);

    state_e            state_q, state_d;
    en_cnt_t           cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]  ld_q, ld_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic [NLAT-1:0]   len_q, len_d;
    logic              busy_q, busy_d;
    logic              lr_q;

    logic [NREQ-1:0]   arb_gnt_s;
    logic [IW-1:0]     arb_idx_s;
    logic              arb_valid_s;

    function automatic logic addr_oob(input logic [AW-1:0] a);
        return 32'(a) >= NLAT;
    endfunction

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt_s),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    // Sequencer next state; the winner's address and data are captured at grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        addr_d  = addr_q;
        ld_d    = ld_q;
        case (state_q)
            IDLE: begin
                if (arb_valid_s) begin
                    state_d = SETUP;
                    ptr_d   = arb_idx_s;
                    win_d   = arb_idx_s;
                    addr_d  = WADDR[arb_idx_s*AW +: AW];
                    ld_d    = WDATA[arb_idx_s*WIDTH +: WIDTH];
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ENABLE;
                cnt_d   = EN_LAST;
            end
            ENABLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so every output is a flop.
    always_comb begin
        gnt_d  = '0;
        ack_d  = '0;
        err_d  = 1'b0;
        len_d  = '0;
        busy_d = 1'b0;
        if (state_d != IDLE) begin
            busy_d       = 1'b1;
            gnt_d[win_d] = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
        // Out-of-range writes run the full sequence with no enable.
        if (state_d == ENABLE && !addr_oob(addr_d)) begin
            len_d = LEN_ONE << addr_d;
        end else begin
            len_d = '0;
        end
        if (state_d == HOLD) begin
            ack_d[win_d] = 1'b1;
            err_d        = addr_oob(addr_d);
        end else begin
            err_d = 1'b0;
        end
    end

    // State and output registers; RESET aborts any write without ACK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);
            win_q   <= '0;
            addr_q  <= '0;
            ld_q    <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            lr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            ld_q    <= ld_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            // Being a flop, LR stays low for one cycle after RESET drops.
            lr_q    <= 1'b1;
        end
    end

    assign GNT  = gnt_q;
    assign ACK  = ack_q;
    assign ERR  = err_q;
    assign LD   = ld_q;
    assign LEN  = len_q;
    assign LR   = lr_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_latch_bank_writer.sv
module tb_latch_bank_writer;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 8;
    localparam int NLAT   = 6;
    localparam int AW     = 3;
    localparam int EN     = 2;
    localparam int HOLD_K = 2 + EN;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*AW-1:0]    waddr;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       GNT, ACK;
    logic                  ERR, LR, BUSY;
    logic [WIDTH-1:0]      LD;
    logic [NLAT-1:0]       LEN;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: transaction timeline position k (0 idle, 1 setup,
    // 2..1+EN enable, 2+EN hold), round-robin pointer, captured write.
    int         m_k, m_ptr, m_win, m_addr;
    logic [7:0] m_ld;
    logic       m_lr;
    logic [7:0] exp_mem [NLAT];
    logic [7:0] bank    [NLAT];

    latch_bank_writer #(.NREQ(NREQ), .WIDTH(WIDTH), .NLAT(NLAT), .AW(AW), .EN_CYCLES(EN)) dut (
        .CLK(clk), .RESET(rst), .REQ(req), .WADDR(waddr), .WDATA(wdata),
        .GNT(GNT), .ACK(ACK), .ERR(ERR), .LD(LD), .LEN(LEN), .LR(LR), .BUSY(BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        bit found;
        int c;
        if (rst) begin
            m_k = 0; m_ptr = NREQ - 1; m_ld = 8'h00; m_lr = 1'b0;
        end else begin
            m_lr = 1'b1;
            if (m_k > 0) begin
                m_k = (m_k == HOLD_K) ? 0 : m_k + 1;
            end else if (req != 4'b0000) begin
                found = 1'b0;
                for (int off = 1; off <= NREQ; off++) begin
                    c = (m_ptr + off) % NREQ;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        m_win = c;
                    end
                end
                m_k    = 1;
                m_ptr  = m_win;
                m_addr = int'(waddr[m_win*AW +: AW]);
                m_ld   = wdata[m_win*WIDTH +: WIDTH];
            end
        end
        if (m_k == HOLD_K && m_addr < NLAT) exp_mem[m_addr] = m_ld;
        if (!m_lr) for (int i = 0; i < NLAT; i++) exp_mem[i] = 8'h00;
    endtask

    function automatic logic [24:0] model_out();
        logic [3:0] e_gnt, e_ack;
        logic [5:0] e_len;
        logic       e_err;
        e_gnt = (m_k >= 1) ? (4'b0001 << m_win) : 4'b0000;
        e_ack = (m_k == HOLD_K) ? (4'b0001 << m_win) : 4'b0000;
        e_err = (m_k == HOLD_K) && (m_addr >= NLAT);
        e_len = (m_k >= 2 && m_k <= 1 + EN && m_addr < NLAT) ? (6'b000001 << m_addr) : 6'b000000;
        return {e_gnt, e_ack, e_err, m_ld, e_len, m_lr, (m_k != 0)};
    endfunction

    // One clock: advance the model, step the DUT, emulate the latch bank, compare.
    task automatic tick();
        logic [24:0] got, exp;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (!LR) begin
            for (int i = 0; i < NLAT; i++) bank[i] = 8'h00;
        end else begin
            for (int i = 0; i < NLAT; i++) if (LEN[i]) bank[i] = LD;
        end
        got = {GNT, ACK, ERR, LD, LEN, LR, BUSY};
        exp = model_out();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL model cycle=%0d got gnt=%b ack=%b err=%b ld=%h len=%b lr=%b busy=%b expected gnt=%b ack=%b err=%b ld=%h len=%b lr=%b busy=%b",
                     cyc, got[24:21], got[20:17], got[16], got[15:8], got[7:2], got[1], got[0],
                     exp[24:21], exp[20:17], exp[16], exp[15:8], exp[7:2], exp[1], exp[0]);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        err;
        logic [7:0]  ld;
        logic [5:0]  len;
        logic        lr;
        logic        busy;
    } vec_t;

    vec_t tbl [13];
    int   ack_idx [5];
    int   ack_cyc [5];
    int   nack;

    initial begin
        // Single write (req 2, addr 3, A5) then out-of-range write (req 1, addr 7, 5A).
        tbl[0]  = '{1'b1, 4'b0000, 12'h000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 6'b000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0000, 12'h000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 6'b000000, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'b0100, 12'h0C0, 32'h00A5_0000, 4'b0100, 4'b0000, 1'b0, 8'hA5, 6'b000000, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 4'b0100, 12'h0C0, 32'h00A5_0000, 4'b0100, 4'b0000, 1'b0, 8'hA5, 6'b001000, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 4'b0100, 12'h0C0, 32'h00A5_0000, 4'b0100, 4'b0000, 1'b0, 8'hA5, 6'b001000, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 4'b0100, 12'h0C0, 32'h00A5_0000, 4'b0100, 4'b0100, 1'b0, 8'hA5, 6'b000000, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 4'b0000, 12'h000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'hA5, 6'b000000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'b0010, 12'h038, 32'h0000_5A00, 4'b0010, 4'b0000, 1'b0, 8'h5A, 6'b000000, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 4'b0010, 12'h038, 32'h0000_5A00, 4'b0010, 4'b0000, 1'b0, 8'h5A, 6'b000000, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 4'b0010, 12'h038, 32'h0000_5A00, 4'b0010, 4'b0000, 1'b0, 8'h5A, 6'b000000, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 4'b0010, 12'h038, 32'h0000_5A00, 4'b0010, 4'b0010, 1'b1, 8'h5A, 6'b000000, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 12'h000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h5A, 6'b000000, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'b0000, 12'h000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h5A, 6'b000000, 1'b1, 1'b0};

        for (int i = 0; i < NLAT; i++) begin
            exp_mem[i] = 8'h00;
            bank[i]    = 8'h00;
        end
        m_k = 0; m_ptr = NREQ - 1; m_win = 0; m_addr = 0; m_ld = 8'h00; m_lr = 1'b0;

        // Reset, then LR stays low for the single cycle after RESET falls.
        rst = 1'b1; req = '0; waddr = '0; wdata = '0;
        tick();
        tick();
        check("reset_outputs", {20'h0, GNT, ACK, LEN, BUSY, ERR}, 32'h0);
        rst = 1'b0;
        #1;
        check("lr_low_after_release", {31'h0, LR}, 32'h0);
        tick();
        check("lr_high", {31'h0, LR}, 32'h1);

        // Table-driven single and out-of-range writes.
        for (int v = 0; v < 13; v++) begin
            rst = tbl[v].rst; req = tbl[v].req; waddr = tbl[v].waddr; wdata = tbl[v].wdata;
            tick();
            check($sformatf("vec%0d", v), {7'h0, GNT, ACK, ERR, LD, LEN, LR, BUSY},
                  {7'h0, tbl[v].gnt, tbl[v].ack, tbl[v].err, tbl[v].ld, tbl[v].len, tbl[v].lr, tbl[v].busy});
        end
        check("latch_word3", {24'h0, bank[3]}, 32'hA5);

        // Contention: all four hold REQ; expect grants 0,1,2,3,0 five cycles apart.
        rst = 1'b1; tick(); rst = 1'b0;
        waddr = {3'd3, 3'd2, 3'd1, 3'd0};
        wdata = 32'h4433_2211;
        req   = 4'b1111;
        nack  = 0;
        for (int c = 0; c < 60 && nack < 5; c++) begin
            tick();
            if (ACK != 4'b0000) begin
                for (int i = 0; i < NREQ; i++) if (ACK[i]) ack_idx[nack] = i;
                ack_cyc[nack] = cyc;
                nack++;
            end
        end
        req = 4'b0000;
        check("contention_ack_count", nack, 5);
        for (int i = 0; i < nack && i < 5; i++) begin
            check($sformatf("contention_order%0d", i), ack_idx[i], i % NREQ);
            if (i > 0) check($sformatf("contention_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3 + EN);
        end
        tick(); tick();
        for (int i = 0; i < NREQ; i++) check($sformatf("contention_word%0d", i), {24'h0, bank[i]}, 32'h11 * (i + 1));

        // Data change after grant: LD and the latch keep the captured 3C.
        req = 4'b1000; waddr = 12'hA00; wdata = 32'h3C00_0000;
        for (int c = 0; c < 10 && LEN == 6'b000000; c++) tick();
        check("dchg_enable_reached", {26'h0, LEN}, 32'h20);
        wdata = 32'hFF00_0000;
        for (int c = 0; c < 10 && ACK == 4'b0000; c++) tick();
        check("dchg_ack", {28'h0, ACK}, 32'h8);
        check("dchg_ld", {24'h0, LD}, 32'h3C);
        req = 4'b0000;
        tick();
        check("dchg_latch", {24'h0, bank[5]}, 32'h3C);

        // Reset during the first ENABLE cycle: no ACK, back to IDLE, requester 0 first.
        req = 4'b0100; waddr = 12'h040; wdata = 32'h0077_0000;
        for (int c = 0; c < 10 && LEN == 6'b000000; c++) tick();
        check("rstmid_enable_reached", {26'h0, LEN}, 32'h02);
        rst = 1'b1;
        tick();
        check("rstmid_quiet", {21'h0, LEN, ACK, BUSY}, 32'h0);
        rst = 1'b0; req = 4'b1111; waddr = '0; wdata = 32'h1234_5678;
        tick();
        check("rstmid_prio0", {28'h0, GNT}, 32'h1);
        req = 4'b0000;
        for (int c = 0; c < 6; c++) tick();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (ACK[i]) begin
                    req[i] = 1'b0;
                end else if (GNT[i]) begin
                    if ($urandom_range(3) == 0) wdata[i*WIDTH +: WIDTH] = 8'($urandom);
                    if ($urandom_range(15) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                    waddr[i*AW +: AW]    = 3'($urandom_range(7));
                    wdata[i*WIDTH +: WIDTH] = 8'($urandom);
                end
            end
            tick();
        end
        req = 4'b0000;
        for (int c = 0; c < 8; c++) tick();
        for (int i = 0; i < NLAT; i++) check($sformatf("final_word%0d", i), {24'h0, bank[i]}, {24'h0, exp_mem[i]});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
